// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor duty path: FSM state encoding,
// default widths, and the offset-plus-saturate rule used by mag_sat.
package mtr_pkg;

    localparam int MTR_SPD_W  = 12;
    localparam int MTR_DUTY_W = 11;
    localparam int DUTY_MAX   = 2**MTR_DUTY_W - 1;
    localparam int SPD_MAX    = 2**(MTR_SPD_W - 1) - 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DEAD = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    // Zero magnitude stays zero so a stop command never receives the friction offset.
    function automatic logic [31:0] sat_duty(input logic [31:0] mag,
                                             input logic [31:0] min_duty,
                                             input logic [31:0] duty_max);
        logic [32:0] sum;
        sum = {1'b0, mag} + {1'b0, min_duty};
        if (mag == '0)
            return '0;
        else if (sum > {1'b0, duty_max})
            return duty_max;
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/mtr_duty_ctrl_mag_sat.sv
// Combinational |speed| -> duty conversion with friction offset and saturation.
// Kept standalone so the steer path can reuse the same mapping.
module mag_sat
    import mtr_pkg::*;
#(
    parameter int SPD_W    = MTR_SPD_W,
    parameter int DUTY_W   = MTR_DUTY_W,
    parameter int MIN_DUTY = 64
) (
    input  logic signed [SPD_W-1:0]  spd,
    output logic        [DUTY_W-1:0] duty,
    output logic                     neg
);

    localparam logic [SPD_W-1:0] SPD_MOST_NEG = {1'b1, {(SPD_W-1){1'b0}}};

    logic [SPD_W-1:0] mag;

    // The most negative code has no positive twin; clamp it to the largest positive.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        mag = spd;
        if (spd == SPD_MOST_NEG)
            mag = ~SPD_MOST_NEG;
        else if (spd[SPD_W-1])
            mag = -spd;
    end

    always_comb begin
        duty = DUTY_W'(sat_duty(32'(mag), 32'(MIN_DUTY), 32'(2**DUTY_W - 1)));
    end

    assign neg = spd[SPD_W-1];

endmodule

// File: rtl/mtr_duty_ctrl.sv
// Speed command to PWM duty/direction, updating only at PWM period starts and
// inserting a zero-duty dead interval whenever the motor direction reverses.
module mtr_duty_ctrl
    import mtr_pkg::*;
#(
    parameter int SPD_W    = 12,
    parameter int DUTY_W   = 11,
    parameter int MIN_DUTY = 64,
    parameter int DEAD_CYC = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [SPD_W-1:0]  spd,
    input  logic                     spd_vld,
    input  logic                     prd_strt,
    output logic        [DUTY_W-1:0] duty,
    output logic                     rev,
    output logic                     busy
);

    localparam int              CNT_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYC - 1);

    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_neg;
    logic [DUTY_W-1:0] tgt_duty;
    logic              tgt_rev;
    logic [CNT_W-1:0]  dead_cnt;
    state_t            state;

    mag_sat #(
        .SPD_W    (SPD_W),
        .DUTY_W   (DUTY_W),
        .MIN_DUTY (MIN_DUTY)
    ) u_mag_sat (
        .spd  (spd),
        .duty (cmd_duty),
        .neg  (cmd_neg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values,
            // which is what lets a coincident prd_strt act on the previously held target.
            tgt_duty <= '0;
            tgt_rev  <= 1'b0;
            duty     <= '0;
            rev      <= 1'b0;
            busy     <= 1'b0;
            dead_cnt <= '0;
            state    <= ST_RUN;
        end else begin
            if (spd_vld) begin
                tgt_duty <= cmd_duty;
                tgt_rev  <= cmd_neg;
            end

            if (!en) begin
                duty     <= '0;
                busy     <= 1'b0;
                dead_cnt <= '0;
                state    <= ST_RUN;
            end else begin
                unique case (state)
                    ST_RUN: begin
                        if (prd_strt) begin
                            // A zero target never flips direction, so it takes the plain path.
                            if (tgt_duty != '0 && tgt_rev != rev) begin
                                duty     <= '0;
                                dead_cnt <= '0;
                                busy     <= 1'b1;
                                state    <= ST_DEAD;
                            end else begin
                                duty <= tgt_duty;
                            end
                        end
                    end
                    ST_DEAD: begin
                        dead_cnt <= dead_cnt + 1'b1;
                        if (dead_cnt == CNT_LAST)
                            state <= ST_SWAP;
                    end
                    ST_SWAP: begin
                        if (prd_strt) begin
                            rev   <= tgt_rev;
                            duty  <= tgt_duty;
                            busy  <= 1'b0;
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        duty  <= '0;
                        busy  <= 1'b0;
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Self-checking bench for mtr_duty_ctrl: directed test-plan scenarios with literal
// expectations, then randomized traffic against a time-based behavioural model.
module tb_mtr_duty_ctrl;

    localparam int SPD_W    = 12;
    localparam int DUTY_W   = 11;
    localparam int MIN_DUTY = 64;
    localparam int DEAD_CYC = 256;
    localparam int DMAX     = 2**DUTY_W - 1;
    localparam int SMAX     = 2**(SPD_W-1) - 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en = 1'b0;
    logic signed [SPD_W-1:0]  spd = '0;
    logic                     spd_vld = 1'b0;
    logic                     prd_strt = 1'b0;
    logic        [DUTY_W-1:0] duty;
    logic                     rev;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mtr_duty_ctrl #(
        .SPD_W    (SPD_W),
        .DUTY_W   (DUTY_W),
        .MIN_DUTY (MIN_DUTY),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spd      (spd),
        .spd_vld  (spd_vld),
        .prd_strt (prd_strt),
        .duty     (duty),
        .rev      (rev),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference mapping straight from the rules: |spd| clamped, offset, saturated.
    function automatic int exp_duty(input int s);
        int m;
        m = (s < 0) ? -s : s;
        if (m > SMAX) m = SMAX;
        if (m == 0) return 0;
        return (m + MIN_DUTY > DMAX) ? DMAX : m + MIN_DUTY;
    endfunction

    // Behavioural model: a reversal is a pending flag plus the cycle it began;
    // it completes on the first period start more than DEAD_CYC cycles later.
    int m_cyc = 0;
    int m_start = 0;
    bit m_pend = 1'b0;
    int m_duty = 0;
    int m_rev = 0;
    int m_tgt_duty = 0;
    int m_tgt_rev = 0;

    always @(posedge clk) begin
        m_cyc++;
        if (rst) begin
            m_pend = 1'b0; m_duty = 0; m_rev = 0; m_tgt_duty = 0; m_tgt_rev = 0;
        end else begin
            if (!en) begin
                m_duty = 0;
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (prd_strt && (m_cyc - m_start > DEAD_CYC)) begin
                    m_rev  = m_tgt_rev;
                    m_duty = m_tgt_duty;
                    m_pend = 1'b0;
                end
            end else if (prd_strt) begin
                if (m_tgt_duty != 0 && m_tgt_rev != m_rev) begin
                    m_pend  = 1'b1;
                    m_start = m_cyc;
                    m_duty  = 0;
                end else begin
                    m_duty = m_tgt_duty;
                end
            end
            if (spd_vld) begin
                m_tgt_duty = exp_duty(int'(spd));
                m_tgt_rev  = (spd < 0) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_duty", int'(duty), m_duty);
            check("model_rev", int'(rev), m_rev);
            check("model_busy", int'(busy), int'(m_pend));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int v);
        spd = SPD_W'(v);
        spd_vld = 1'b1;
        step(1);
        spd_vld = 1'b0;
    endtask

    task automatic prd();
        prd_strt = 1'b1;
        step(1);
        prd_strt = 1'b0;
    endtask

    initial begin
        int dead_nz;
        int per;
        int cnt;
        int sel;

        check("mdl_100", exp_duty(100), 164);
        check("mdl_1", exp_duty(1), 65);
        check("mdl_neg_max", exp_duty(-2048), 2047);
        check("mdl_zero", exp_duty(0), 0);

        step(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_duty", int'(duty), 0);
        check("rst_rev", int'(rev), 0);
        check("rst_busy", int'(busy), 0);

        en = 1'b1;
        cmd(100);
        step(2);
        check("pre_prd_duty", int'(duty), 0);
        prd();
        check("fwd_duty", int'(duty), 164);
        check("fwd_rev", int'(rev), 0);
        check("fwd_busy", int'(busy), 0);

        cmd(2047);
        prd();
        check("sat_duty", int'(duty), 2047);
        cmd(100);
        prd();

        cmd(-100);
        prd();
        check("rev_start_duty", int'(duty), 0);
        check("rev_start_busy", int'(busy), 1);
        dead_nz = 0;
        for (int i = 0; i < DEAD_CYC; i++) begin
            prd_strt = (i % 50 == 0);
            step(1);
            if (duty != '0) dead_nz++;
        end
        prd_strt = 1'b0;
        check("dead_duty_nonzero_cycles", dead_nz, 0);
        check("dead_busy", int'(busy), 1);
        prd();
        check("rev_done_duty", int'(duty), 164);
        check("rev_done_rev", int'(rev), 1);
        check("rev_done_busy", int'(busy), 0);

        cmd(-2048);
        prd();
        check("neg_max_duty", int'(duty), 2047);
        check("neg_max_rev", int'(rev), 1);
        cmd(0);
        prd();
        check("zero_duty", int'(duty), 0);
        check("zero_rev", int'(rev), 1);

        cmd(300);
        prd();
        check("mid_dead_busy", int'(busy), 1);
        step(10);
        cmd(50);
        step(DEAD_CYC);
        prd();
        check("mid_dead_duty", int'(duty), 114);
        check("mid_dead_rev", int'(rev), 0);

        cmd(80);
        spd = SPD_W'(200);
        spd_vld = 1'b1;
        prd_strt = 1'b1;
        step(1);
        spd_vld = 1'b0;
        prd_strt = 1'b0;
        check("coinc_old_duty", int'(duty), 144);
        prd();
        check("coinc_new_duty", int'(duty), 264);

        cmd(-100);
        prd();
        step(5);
        en = 1'b0;
        step(1);
        check("en_low_duty", int'(duty), 0);
        check("en_low_busy", int'(busy), 0);
        check("en_low_rev", int'(rev), 0);
        en = 1'b1;
        step(2);
        prd();
        check("re_dead_busy", int'(busy), 1);
        step(DEAD_CYC);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("swap_rst_duty", int'(duty), 0);
        check("swap_rst_rev", int'(rev), 0);
        check("swap_rst_busy", int'(busy), 0);
        prd();
        check("post_rst_duty", int'(duty), 0);

        per = 32;
        cnt = 0;
        for (int c = 0; c < 8000; c++) begin
            prd_strt = (cnt == 0);
            cnt++;
            if (cnt >= per) begin
                cnt = 0;
                per = $urandom_range(96, 16);
            end
            en  = ($urandom % 97) != 0;
            rst = ($urandom % 3000) == 0;
            spd_vld = ($urandom % 40) == 0;
            sel = $urandom % 6;
            case (sel)
                0:       spd = '0;
                1:       spd = {1'b1, {(SPD_W-1){1'b0}}};
                2:       spd = {1'b0, {(SPD_W-1){1'b1}}};
                3:       spd = SPD_W'(int'($urandom_range(40, 0)) - 20);
                default: spd = SPD_W'($urandom);
            endcase
            step(1);
        end
        prd_strt = 1'b0;
        spd_vld = 1'b0;
        rst = 1'b0;
        step(2);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mtr_duty_ctrl.md
Name: mtr_duty_ctrl

Overview:
Converts a signed motor-speed command into the 11-bit unsigned duty and direction bit that drive one motor's 11-bit PWM generator.
- Adds a minimum-duty offset to overcome static friction, and saturates the result.
- Enforces a dead interval of zero duty whenever motor direction reverses.
- Updates duty and direction only at PWM period boundaries, so the downstream PWM never sees a mid-period change.
- Sits between the balance/steer controller and the PWM generator; instantiated once per motor.

Parameters:
SPD_W, 12, width of signed speed command
DUTY_W, 11, width of duty output (matches the PWM counter)
MIN_DUTY, 64, offset added to any nonzero magnitude
DEAD_CYC, 256, clock cycles of forced zero duty on direction reversal

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  motor enable; low forces zero duty
spd  in  SPD_W  signed speed command, two's complement
spd_vld  in  1  one-cycle strobe; capture spd
prd_strt  in  1  one-cycle pulse coincident with the PWM counter at 0
duty  out  DUTY_W  registered duty to the PWM generator
rev  out  1  registered direction, 1 = reverse
busy  out  1  high while a direction reversal is in progress

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst). On rst: duty=0, rev=0, busy=0, state=RUN, tgt_duty=0, tgt_rev=0, dead_cnt=0.
- Target capture, on spd_vld:
  - mag = |spd|, with -2^(SPD_W-1) mapped to 2^(SPD_W-1)-1.
  - tgt_duty = 0 if mag==0, else min(mag+MIN_DUTY, 2^DUTY_W-1). Compute the sum one bit wider before saturating.
  - tgt_rev = spd[SPD_W-1].
- Capture timing: the target registers update the cycle after spd_vld. If spd_vld and prd_strt coincide, that prd_strt acts on the previously held target.
- States: RUN, DEAD, SWAP.
- RUN, on prd_strt:
  - If tgt_duty!=0 and tgt_rev!=rev: duty<=0, dead_cnt<=0, go to DEAD.
  - Otherwise: duty<=tgt_duty; rev is unchanged (a zero target never flips direction).
- DEAD:
  - duty held at 0; dead_cnt increments every clk.
  - When dead_cnt==DEAD_CYC-1, go to SWAP.
  - prd_strt is ignored in this state.
- SWAP, on next prd_strt: rev<=tgt_rev, duty<=tgt_duty, go to RUN. The target may have changed during DEAD; use the current tgt values, even if rev then does not change.
- busy = (state!=RUN), registered alongside state.
- en low: next clk duty<=0, state<=RUN, dead_cnt<=0; rev holds. Targets still capture. When en returns high, normal RUN rules apply at the next prd_strt.
- Latency:
  - Command-to-duty is 1 cycle after the first prd_strt that follows target capture.
  - Reversal latency is ≥ DEAD_CYC cycles plus the wait to the next prd_strt.
- Priority: rst > en low > state machine.
- Duty and rev change only on a clk where prd_strt=1 (or on en low / rst).

Decomposition:
- Package mtr_pkg:
  - state enum {RUN, DEAD, SWAP}
  - localparams DUTY_MAX = 2^DUTY_W-1 and SPD_MAX
  - function sat_duty(mag) implementing offset plus saturation
- One natural sub-module: mag_sat, combinational abs + offset + saturate. Instantiate it so the steer path can reuse it.
- The state machine and counters stay in mtr_duty_ctrl.

Test Plan:
- Forward command: rst, en=1, spd=100 with spd_vld, then prd_strt -> next cycle duty=164, rev=0, busy=0. duty does not change before prd_strt.
- Saturation and extreme negative: spd=2047 -> duty=2047, rev=0. From rev=1 state, spd=-2048 -> duty=2047, rev=1. spd=0 -> duty=0, rev unchanged.
- Reversal: duty=164/rev=0, then spd=-100 and prd_strt -> duty=0, busy=1. duty stays 0 for 256 cycles even with prd_strt pulses. Then the next prd_strt -> duty=164, rev=1, busy=0.
- Target change mid-DEAD: reversal started, then spd=+50 during DEAD -> after the dead interval and prd_strt: rev=0, duty=114.
- Coincident strobes: spd_vld (spd=200) and prd_strt in the same cycle -> duty takes the old target. The following prd_strt -> duty=264.
- en and rst mid-reversal:
  - en=0 during DEAD -> next cycle duty=0, busy=0, rev held.
  - rst asserted during SWAP -> next cycle duty=0, rev=0, busy=0; the following prd_strt keeps duty=0.
